// File: rtl/im_loader.sv
// Byte-stream program loader: parses framed bytes (sync, count, opcode/literal pairs,
// checksum) and writes 15-bit instruction words into instruction memory while holding the core.
module im_loader #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         WORD_W     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [7:0]        im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CNT  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_CHK   = 2'd2;

    logic [2:0]        state_reg, state_next;
    logic [8:0]        count_reg;
    logic [8:0]        idx_reg;
    logic [7:0]        chk_reg;
    logic [6:0]        opcode_reg;
    logic              in_ready_reg;
    logic              im_we_reg;
    logic [7:0]        im_addr_reg;
    logic [WORD_W-1:0] im_wdata_reg;
    logic              cpu_hold_reg;
    logic              done_reg;
    logic              err_reg;
    logic [1:0]        err_code_reg;

    logic accept;
    logic last_word;

    assign accept    = in_valid && in_ready_reg;
    // COUNT of 0 is stored as 256, so the 9-bit index compare covers the full range.
    assign last_word = (idx_reg + 9'd1) == count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept && in_data == SYNC_BYTE) state_next = S_CNT;
            S_CNT:  if (accept) state_next = S_HI;
            S_HI:   if (accept) state_next = in_data[7] ? S_ERR : S_LO;
            S_LO:   if (accept) state_next = last_word ? S_CHK : S_HI;
            S_CHK:  if (accept) state_next = (in_data == chk_reg) ? S_DONE : S_ERR;
            S_DONE: state_next = S_IDLE;
            S_ERR:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            idx_reg      <= '0;
            chk_reg      <= '0;
            opcode_reg   <= '0;
            in_ready_reg <= 1'b0;
            im_we_reg    <= 1'b0;
            im_addr_reg  <= START_ADDR;
            im_wdata_reg <= '0;
            cpu_hold_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            // Ready drops for the single DONE/ERR cycle that closes every frame.
            in_ready_reg <= (state_next != S_DONE) && (state_next != S_ERR);
            im_we_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;

            if (accept) begin
                case (state_reg)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            cpu_hold_reg <= 1'b1;
                            err_code_reg <= ERR_NONE;
                            idx_reg      <= '0;
                            chk_reg      <= '0;
                        end
                    end
                    S_CNT: begin
                        count_reg <= {(in_data == 8'h00), in_data};
                        chk_reg   <= in_data;
                    end
                    S_HI: begin
                        if (in_data[7]) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= ERR_FRAME;
                        end else begin
                            opcode_reg <= in_data[6:0];
                            chk_reg    <= chk_reg ^ in_data;
                        end
                    end
                    S_LO: begin
                        chk_reg      <= chk_reg ^ in_data;
                        im_we_reg    <= 1'b1;
                        im_addr_reg  <= START_ADDR + idx_reg[7:0];
                        im_wdata_reg <= {opcode_reg, in_data};
                        idx_reg      <= idx_reg + 9'd1;
                    end
                    S_CHK: begin
                        if (in_data == chk_reg) begin
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            err_reg      <= 1'b1;
                            err_code_reg <= ERR_CHK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready = in_ready_reg;
    assign im_we    = im_we_reg;
    assign im_addr  = im_addr_reg;
    assign im_wdata = im_wdata_reg;
    assign cpu_hold = cpu_hold_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule
